// File: rtl/alu_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : alu_pkg
// Brief  : Shared definitions for the ALU result path. Covers the add_sub
//          result width, the sign-magnitude field layout and the state
//          encoding of the result accumulator.
// Rev    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Width of an add_sub result word: 1 sign bit plus 3 magnitude bits.
  localparam int RES_W    = 4;
  localparam int SIGN_IDX = RES_W - 1;
  localparam int MAG_HI   = RES_W - 2;
  localparam int MAG_LO   = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Fold negative zero (sign set, magnitude 0) onto +0.
  function automatic logic [RES_W-1:0] sm_norm_res(input logic [RES_W-1:0] v);
    logic [RES_W-1:0] r;
    r = v;
    if (v[MAG_HI:MAG_LO] == '0) begin
      r[SIGN_IDX] = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_acc_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : alu_result_acc_if
// Brief  : Input stream, output handshake and result bundle of the ALU
//          result accumulator. The master side is the producer/consumer
//          environment; the slave side is the accumulator.
// Rev    : 1.0  initial release
// ============================================================================
interface alu_result_acc_if #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 6
) ();
  import alu_pkg::*;

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] R;
  logic             SF;
  logic             ZF;
  logic             DZF;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             acc_sf;
  logic             acc_zf;
  logic             ovf;
  logic             dz;
  logic [CNT_W-1:0] count;

  modport master (
    output start, in_valid, R, SF, ZF, DZF, out_ready,
    input  in_ready, out_valid, acc, acc_sf, acc_zf, ovf, dz, count
  );

  modport slave (
    input  start, in_valid, R, SF, ZF, DZF, out_ready,
    output in_ready, out_valid, acc, acc_sf, acc_zf, ovf, dz, count
  );

endinterface
`default_nettype wire

// File: rtl/sm_add.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : sm_add
// Brief  : Combinational saturating sign-magnitude adder. Adds a RES_W-bit
//          sign-magnitude operand to an ACC_W-bit sign-magnitude accumulator,
//          clamping the magnitude to its maximum and flagging saturation.
//          Negative zero is folded to +0 on both inputs and on the output.
// Rev    : 1.0  initial release
// ============================================================================
module sm_add
  import alu_pkg::*;
#(
  parameter int ACC_W = 6
) (
  input  logic [ACC_W-1:0] acc_in,
  input  logic [RES_W-1:0] operand,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  localparam int MAG_W = ACC_W - 1;
  // Magnitudes are handled ACC_W bits wide so a same-sign add cannot wrap.
  localparam logic [ACC_W-1:0] c_mag_max = {1'b0, {MAG_W{1'b1}}};

  logic [RES_W-1:0] w_op;
  logic             w_a_sign;
  logic [ACC_W-1:0] w_a_mag;
  logic             w_b_sign;
  logic [ACC_W-1:0] w_b_mag;
  logic             w_sign;
  logic [ACC_W-1:0] w_mag;
  logic [ACC_W-1:0] w_mag_clamped;

  assign w_op     = sm_norm_res(operand);
  assign w_a_mag  = {1'b0, acc_in[MAG_W-1:0]};
  assign w_a_sign = acc_in[ACC_W-1] & (|acc_in[MAG_W-1:0]);
  assign w_b_mag  = ACC_W'(w_op[MAG_HI:MAG_LO]);
  assign w_b_sign = w_op[SIGN_IDX];

  // Signed-magnitude add: same signs add, differing signs subtract the
  // smaller magnitude from the larger and take the larger one's sign.
  always_comb begin
    w_sign = 1'b0;
    w_mag  = '0;
    if (w_a_sign == w_b_sign) begin
      w_mag  = w_a_mag + w_b_mag;
      w_sign = w_a_sign;
    end else if (w_a_mag >= w_b_mag) begin
      w_mag  = w_a_mag - w_b_mag;
      w_sign = w_a_sign;
    end else begin
      w_mag  = w_b_mag - w_a_mag;
      w_sign = w_b_sign;
    end
  end

  assign sat           = (w_mag > c_mag_max);
  assign w_mag_clamped = sat ? c_mag_max : w_mag;
  // A zero magnitude always leaves with a positive sign.
  assign sum = {w_sign & (|w_mag_clamped[MAG_W-1:0]), w_mag_clamped[MAG_W-1:0]};

endmodule
`default_nettype wire

// File: rtl/alu_result_acc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : alu_result_acc
// Brief  : Accumulates a run of NUM_SAMPLES add_sub results into a
//          saturating sign-magnitude accumulator. The run is started by a
//          start pulse, and the result is presented through a valid/ready
//          handshake together with registered flags and sticky error bits.
// Rev    : 1.0  initial release
// ============================================================================
module alu_result_acc
  import alu_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_acc_if.slave     bus
);

  localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_SAMPLES);

  state_t           r_state;
  state_t           r_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic             r_acc_sf;
  logic             r_acc_zf;
  logic             r_ovf;
  logic             r_dz;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic             w_unused_flags;

  // SF/ZF come along with the result for information only.
  assign w_unused_flags = bus.SF ^ bus.ZF;

  assign w_accept  = bus.in_valid && (r_state == ACCUM);
  assign w_cnt_nxt = r_count + CNT_W'(1);

  sm_add #(
    .ACC_W (ACC_W)
  ) u_sm_add (
    .acc_in  (r_acc),
    .operand (bus.R),
    .sum     (w_sum),
    .sat     (w_sat)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= r_state_nxt;
    end
  end

  // Next-state logic: start in IDLE, last sample in ACCUM, out_ready in DONE.
  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          r_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept && (w_cnt_nxt == c_last)) begin
          r_state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          r_state_nxt = IDLE;
        end
      end
      default: begin
        r_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: clear on start, update on each accepted sample, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_acc_sf <= 1'b0;
      r_acc_zf <= 1'b1;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_count  <= '0;
    end else if ((r_state == IDLE) && bus.start) begin
      r_acc    <= '0;
      r_acc_sf <= 1'b0;
      r_acc_zf <= 1'b1;
      r_ovf    <= 1'b0;
      r_dz     <= 1'b0;
      r_count  <= '0;
    end else if (w_accept) begin
      r_count <= w_cnt_nxt;
      if (bus.DZF) begin
        // Invalid sample: counted and flagged, accumulator untouched.
        r_dz <= 1'b1;
      end else begin
        r_acc    <= w_sum;
        r_acc_sf <= w_sum[ACC_W-1];
        r_acc_zf <= ~(|w_sum[ACC_W-2:0]);
        if (w_sat) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_valid = (r_state == DONE);
  assign bus.acc       = r_acc;
  assign bus.acc_sf    = r_acc_sf;
  assign bus.acc_zf    = r_acc_zf;
  assign bus.ovf       = r_ovf;
  assign bus.dz        = r_dz;
  assign bus.count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_acc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_alu_result_acc
// Brief  : Directed bench for alu_result_acc with a 4-sample and an
//          8-sample instance sharing the input stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_result_acc;

  logic clk;
  logic rst_n;
  logic start4;
  logic start8;
  logic in_valid;
  logic [3:0] r_in;
  logic dzf;
  logic out_ready;

  int n_checks;
  int n_errors;

  alu_result_acc_if #(.NUM_SAMPLES(4), .ACC_W(6)) if4 ();
  alu_result_acc_if #(.NUM_SAMPLES(8), .ACC_W(6)) if8 ();

  assign if4.start     = start4;
  assign if4.in_valid  = in_valid;
  assign if4.R         = r_in;
  assign if4.SF        = r_in[3];
  assign if4.ZF        = (r_in[2:0] == 3'd0);
  assign if4.DZF       = dzf;
  assign if4.out_ready = out_ready;

  assign if8.start     = start8;
  assign if8.in_valid  = in_valid;
  assign if8.R         = r_in;
  assign if8.SF        = r_in[3];
  assign if8.ZF        = (r_in[2:0] == 3'd0);
  assign if8.DZF       = dzf;
  assign if8.out_ready = out_ready;

  alu_result_acc #(.NUM_SAMPLES(4), .ACC_W(6)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  alu_result_acc #(.NUM_SAMPLES(8), .ACC_W(6)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observation vectors: {acc, acc_sf, acc_zf, ovf, dz, count, in_ready, out_valid}
  logic [14:0] obs4;
  logic [15:0] obs8;
  assign obs4 = {if4.acc, if4.acc_sf, if4.acc_zf, if4.ovf, if4.dz, if4.count, if4.in_ready, if4.out_valid};
  assign obs8 = {if8.acc, if8.acc_sf, if8.acc_zf, if8.ovf, if8.dz, if8.count, if8.in_ready, if8.out_valid};

  // All tasks start and end 1 time unit after a rising edge.
  task automatic start_run(input bit use8);
    if (use8) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic send(input logic [3:0] r, input logic d);
    in_valid = 1'b1;
    r_in     = r;
    dzf      = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dzf      = 1'b0;
    r_in     = 4'b0000;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] e4;
    logic [15:0] e8;
    e4 = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    e8 = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    n_checks++;
    if (obs4 !== e4) begin
      n_errors++;
      $display("FAIL reset_held4 got=%b exp=%b", obs4, e4);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs4 !== e4) begin
        n_errors++;
        $display("FAIL reset_idle4[%0d] got=%b exp=%b", i, obs4, e4);
      end
      n_checks++;
      if (obs8 !== e8) begin
        n_errors++;
        $display("FAIL reset_idle8[%0d] got=%b exp=%b", i, obs8, e8);
      end
    end
  endtask

  task automatic test_cancel();
    logic [14:0] e;
    start_run(1'b0);
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL cancel_start got=%b exp=%b", obs4, e);
    end
    send(4'b0011, 1'b0);
    send(4'b0010, 1'b0);
    send(4'b1001, 1'b0);
    // +3 +2 -1 = +4, still accumulating
    e = {6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL cancel_third got=%b exp=%b", obs4, e);
    end
    send(4'b1100, 1'b0);
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL cancel_done got=%b exp=%b", obs4, e);
    end
    release_out();
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL cancel_idle got=%b exp=%b", obs4, e);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] e;
    start_run(1'b1);
    for (int i = 0; i < 5; i++) send(4'b1110, 1'b0);
    // -30: one step below the clamp
    e = {6'b111110, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0};
    n_checks++;
    if (obs8 !== e) begin
      n_errors++;
      $display("FAIL sat_neg_pre got=%b exp=%b", obs8, e);
    end
    for (int i = 0; i < 3; i++) send(4'b1110, 1'b0);
    e = {6'b111111, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1};
    n_checks++;
    if (obs8 !== e) begin
      n_errors++;
      $display("FAIL sat_neg got=%b exp=%b", obs8, e);
    end
    release_out();
    start_run(1'b1);
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
    n_checks++;
    if (obs8 !== e) begin
      n_errors++;
      $display("FAIL sat_restart got=%b exp=%b", obs8, e);
    end
    for (int i = 0; i < 8; i++) send(4'b0110, 1'b0);
    e = {6'b011111, 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1};
    n_checks++;
    if (obs8 !== e) begin
      n_errors++;
      $display("FAIL sat_pos got=%b exp=%b", obs8, e);
    end
    release_out();
  endtask

  task automatic test_negzero_dzf();
    logic [14:0] e;
    start_run(1'b0);
    send(4'b1000, 1'b0);
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL negzero_first got=%b exp=%b", obs4, e);
    end
    send(4'b1010, 1'b0);
    send(4'b0011, 1'b1);
    // DZF sample counted, acc stays -2
    e = {6'b100010, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL dzf_hold got=%b exp=%b", obs4, e);
    end
    send(4'b0010, 1'b0);
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL negzero_done got=%b exp=%b", obs4, e);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [14:0] e;
    start_run(1'b0);
    for (int i = 0; i < 4; i++) send(4'b0001, 1'b0);
    e = {6'b000100, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    in_valid = 1'b1;
    r_in     = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (obs4 !== e) begin
        n_errors++;
        $display("FAIL backpressure[%0d] got=%b exp=%b", i, obs4, e);
      end
    end
    in_valid = 1'b0;
    r_in     = 4'b0000;
    release_out();
    // start pulse mid-run must not clear the accumulator
    start_run(1'b0);
    send(4'b0011, 1'b0);
    send(4'b0011, 1'b0);
    start4 = 1'b1;
    send(4'b0011, 1'b0);
    start4 = 1'b0;
    e = {6'b001001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL start_ignored got=%b exp=%b", obs4, e);
    end
    send(4'b0001, 1'b0);
    e = {6'b001010, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL start_ignored_done got=%b exp=%b", obs4, e);
    end
    release_out();
  endtask

  task automatic test_midrun_reset();
    logic [14:0] e;
    start_run(1'b0);
    send(4'b0101, 1'b0);
    send(4'b0101, 1'b0);
    rst_n = 1'b0;
    #1;
    e = {6'b000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL midrun_reset got=%b exp=%b", obs4, e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_run(1'b0);
    send(4'b1001, 1'b0);
    send(4'b1010, 1'b0);
    send(4'b0011, 1'b0);
    send(4'b1100, 1'b0);
    // -1 -2 +3 -4 = -4
    e = {6'b100100, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1};
    n_checks++;
    if (obs4 !== e) begin
      n_errors++;
      $display("FAIL post_reset_run got=%b exp=%b", obs4, e);
    end
    release_out();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start4    = 1'b0;
    start8    = 1'b0;
    in_valid  = 1'b0;
    r_in      = 4'b0000;
    dzf       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_cancel();
    test_saturation();
    test_negzero_dzf();
    test_back_to_back();
    test_midrun_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_acc.md
Name: alu_result_acc

Overview:
- Downstream consumer of the add_sub stage. Takes a stream of 4-bit sign-magnitude results plus SF/ZF/DZF flags and accumulates a run of NUM_SAMPLES results into a saturating sign-magnitude accumulator.
- Reports the accumulated value, registered flags and sticky error bits through a valid/ready output handshake.
- Sits between the ALU datapath and the result/readout logic.

Parameters:
- NUM_SAMPLES, 4, number of accepted results per accumulation run (>=1).
- ACC_W, 6, accumulator width in bits: 1 sign bit plus ACC_W-1 magnitude bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a run (honoured only in IDLE).
- in_valid  input  1  R/flags below are valid this cycle.
- in_ready  output  1  block can accept a result this cycle.
- R  input  4  add_sub result, sign-magnitude: R[3] sign, R[2:0] magnitude.
- SF  input  1  add_sub sign flag (informational, not used for arithmetic).
- ZF  input  1  add_sub zero flag (informational).
- DZF  input  1  add_sub invalid/divide-zero flag; sample is not added.
- out_valid  output  1  accumulation run complete, outputs stable.
- out_ready  input  1  consumer takes the result.
- acc  output  ACC_W  accumulated value, sign-magnitude.
- acc_sf  output  1  acc sign bit (registered, equals acc[ACC_W-1]).
- acc_zf  output  1  acc magnitude == 0.
- ovf  output  1  sticky: saturation occurred this run.
- dz  output  1  sticky: at least one DZF sample this run.
- count  output  clog2(NUM_SAMPLES+1)  samples accepted this run.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0, acc_sf=0, acc_zf=1, ovf=0, dz=0, count=0, in_ready=0, out_valid=0. Reset asserted mid-run abandons the run with no output.

FSM states:
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> ACCUM. On the same edge: acc=0, acc_zf=1, acc_sf=0, ovf=0, dz=0, count=0.
- ACCUM:
  - in_ready=1.
  - Accept when in_valid && in_ready. acc, flags and count update on that edge, so they are visible the next cycle.
  - When the accepted sample makes count==NUM_SAMPLES -> DONE.
  - start is ignored in ACCUM.
- DONE:
  - in_ready=0, out_valid=1. acc, flags and count are held.
  - out_ready=1 -> IDLE; outputs keep their values until the next start.
  - in_valid is ignored in DONE.

Arithmetic (per accepted sample, using the sm_add sub-module):
- Input R=1000 (negative zero) is treated as +0.
- DZF=1: the sample is counted, dz is set, and acc is unchanged.
- Same signs: add magnitudes; result sign = common sign.
- Different signs: subtract the smaller magnitude from the larger; result sign = sign of the larger. Equal magnitudes give +0.
- If the magnitude exceeds 2^(ACC_W-1)-1, clamp it to that value, keep the sign, and set ovf. Later samples operate on the clamped value.
- No negative zero ever appears on acc: a zero result always has sign 0.
- acc_zf and acc_sf are recomputed from the new acc on the same edge.

Other timing rules:
- out_valid rises the cycle after the final acceptance.
- Throughput is one sample per cycle in ACCUM.
- Minimum run length is NUM_SAMPLES+2 cycles: start, NUM_SAMPLES accepts, one DONE cycle with out_ready=1.

Decomposition:
- Shared package alu_pkg:
  - RES_W=4 (add_sub result width).
  - State enum {IDLE, ACCUM, DONE}.
  - Sign-magnitude field positions (sign index, magnitude slice).
- One combinational sub-module, sm_add:
  - Saturating sign-magnitude adder: ACC_W accumulator plus RES_W operand.
  - Outputs sum and sat.
  - Negative-zero normalisation on input and output.

Test Plan:
1. Reset check: hold rst_n=0, then release with no start. Expect acc=000000, acc_zf=1, ovf=0, dz=0, count=0, in_ready=0, out_valid=0 indefinitely.
2. Cancelling run (NUM_SAMPLES=4): start, then R=0011, 0010, 1001, 1100 on consecutive cycles. Expect acc=000000, acc_zf=1, acc_sf=0, count=4, out_valid=1 the cycle after the 4th accept. Pulse out_ready -> IDLE.
3. Saturation (NUM_SAMPLES=8): eight samples of R=1110 (-6). Expect acc=111111, acc_sf=1, ovf=1. Repeat with R=0110 (+6): expect acc=011111, ovf=1.
4. Negative zero and DZF (NUM_SAMPLES=4): samples 1000, 1010, 0011 with DZF=1, 0010. Expect acc=000000 with sign 0, acc_zf=1, dz=1, count=4.
5. Backpressure:
   - In DONE, hold out_ready=0 for 5 cycles while driving in_valid=1, R=0001. Expect acc and count unchanged and out_valid held.
   - A start pulse during ACCUM does not clear acc.
6. Mid-run reset: assert rst_n=0 after 2 of 4 samples. Expect all outputs at reset values immediately (async). A following full run accumulates from 0.
